// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment shift-out link: glyph table, frame geometry, receiver states.
package sseg_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned NIBBLES    = 8;
  localparam int unsigned CNT_W      = 7;

  // Segment pattern for each hex digit, index = nibble value; bit 7 (DP) is always clear.
  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef enum logic {IDLE, RECV} state_t;

endpackage

// File: rtl/sseg_decode.sv
// Combinational glyph-to-nibble decoder; unknown patterns (including any with DP set) flag an error.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [7:0] seg,
  output logic       err_c,
  output logic [3:0] nib_c
);

  always_comb begin
    err_c = 1'b1;
    nib_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        err_c = 1'b0;
        nib_c = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_rx.sv
// Seven-segment link receiver: synchronizes ss_clk/ss_dout/ss_en, captures a 64-bit frame,
// checks its length and decodes the eight segment bytes back to a 32-bit word.
module sseg_rx
  import sseg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ss_dout,
  input  logic                     ss_clk,
  input  logic                     ss_en,
  output logic [4*NIBBLES-1:0]     dout,
  output logic                     dout_valid,
  output logic [FRAME_BITS-1:0]    seg_raw,
  output logic [NIBBLES-1:0]       seg_err,
  output logic                     frame_err
);

  logic [SYNC_STAGES-1:0] dout_sync, clk_sync, en_sync;
  logic                   dout_s, clk_s, en_s, clk_prev;
  logic [2:0]             flush_cnt;
  logic                   flushed_c;

  state_t                 state;
  logic                   armed, overrun;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  sh;

  logic                   rise_c, shift_c, ovr_next_c;
  logic [CNT_W-1:0]       cnt_next_c;
  logic [FRAME_BITS-1:0]  sh_next_c, raw_c;
  logic [NIBBLES-1:0]     err_c;
  logic [4*NIBBLES-1:0]   nib_c;

  // Idle-level synchronizers so reset never creates a false ss_clk edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_sync <= '1;
      clk_sync  <= '1;
      en_sync   <= '1;
      clk_prev  <= 1'b1;
      flush_cnt <= 3'd0;
    end else begin
      dout_sync <= {dout_sync[SYNC_STAGES-2:0], ss_dout};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ss_clk};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], ss_en};
      clk_prev  <= clk_s;
      if (flush_cnt != 3'(SYNC_STAGES)) flush_cnt <= flush_cnt + 3'd1;
    end
  end

  assign dout_s    = dout_sync[SYNC_STAGES-1];
  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign en_s      = en_sync[SYNC_STAGES-1];
  // The reset value of the chain is not a real observation of ss_en; only trust it once refilled.
  assign flushed_c = (flush_cnt == 3'(SYNC_STAGES));

  // Next shift state including an edge that lands in the same cycle as the ss_en rise.
  always_comb begin
    rise_c     = clk_s & ~clk_prev;
    shift_c    = (state == RECV) && rise_c && (bit_cnt < CNT_W'(FRAME_BITS));
    sh_next_c  = shift_c ? {sh[FRAME_BITS-2:0], dout_s} : sh;
    cnt_next_c = shift_c ? bit_cnt + CNT_W'(1) : bit_cnt;
    ovr_next_c = overrun | ((state == RECV) && rise_c && (bit_cnt >= CNT_W'(FRAME_BITS)));
    raw_c      = '0;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      raw_c[8*k +: 8] = sh_next_c[FRAME_BITS-1-8*k -: 8];
    end
  end

  for (genvar k = 0; k < int'(NIBBLES); k++) begin : g_dec
    sseg_decode u_dec (
      .seg   (raw_c[8*k +: 8]),
      .err_c (err_c[k]),
      .nib_c (nib_c[4*k +: 4])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      armed      <= 1'b0;
      overrun    <= 1'b0;
      bit_cnt    <= '0;
      sh         <= '0;
      dout       <= '0;
      seg_raw    <= '0;
      seg_err    <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (en_s && flushed_c) armed <= 1'b1;
          if (!en_s && armed) begin
            state   <= RECV;
            bit_cnt <= '0;
            sh      <= '0;
            overrun <= 1'b0;
          end
        end
        RECV: begin
          sh      <= sh_next_c;
          bit_cnt <= cnt_next_c;
          overrun <= ovr_next_c;
          if (en_s) begin
            state <= IDLE;
            if (cnt_next_c == CNT_W'(FRAME_BITS) && !ovr_next_c) begin
              dout       <= nib_c;
              seg_raw    <= raw_c;
              seg_err    <= err_c;
              dout_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sseg_rx.md
# sseg_rx

Serial receiver and decoder for the seven-segment shift-out link (ss_dout / ss_clk / ss_en). It captures the 64-bit segment stream one frame at a time, checks the framing, and decodes each 8-bit segment pattern back to a hex nibble. It then presents the reconstructed 32-bit display word with a one-cycle valid strobe. It serves as the loopback checker and board-side monitor for the display driver.

## Interface
- SYNC_STAGES, 2: synchronizer depth on ss_clk, ss_dout and ss_en; legal range 2–4.
- clk  input  1  system clock. Must be at least 2x the ss_clk bit rate; the driver uses 4 clk per bit.
- rstn  input  1  reset, asynchronous, active-low.
- ss_dout  input  1  serial segment data.
- ss_clk  input  1  serial clock. Idles high; data is sampled on its rising edge.
- ss_en  input  1  frame envelope. High when idle, low for the whole 64-bit frame.
- dout  output  32  last good decoded word. Nibble k is segment byte k in arrival order.
- dout_valid  output  1  one-clk pulse when dout updates.
- seg_raw  output  64  raw segment bytes of the last complete frame. Byte k sits at [8k+7:8k].
- seg_err  output  8  per-nibble flag: the pattern was not a legal hex glyph, or bit 7 (DP) was set.
- frame_err  output  1  one-clk pulse on a short or long frame.

## Operation
- Inputs first pass through SYNC_STAGES flops. All logic below uses the synchronized versions.
- Rising-edge detect on the synchronized ss_clk: the previous sample is 0 and the current sample is 1.
- State machine, IDLE → RECV → IDLE:
  - IDLE: wait for synchronized ss_en = 0. On entry to RECV, clear bit_cnt (7 bits) and the shift register.
  - RECV: on each ss_clk rising edge with bit_cnt < 64, shift ss_dout into the 64-bit register and increment bit_cnt.
  - RECV exit, ss_en returns high with bit_cnt == 64: commit the frame and return to IDLE.
  - RECV exit, ss_en returns high with bit_cnt ≠ 64: pulse frame_err, discard the frame, return to IDLE.
  - Over-long frame: a 65th edge sets an overrun flag. When ss_en rises, the frame is discarded with frame_err.
- Bit order:
  - Bit b of the frame belongs to byte b/8.
  - Within each byte the MSB arrives first: frame bit b = segment bit 7 − (b mod 8).
  - Byte 0, which arrives first, decodes to dout[3:0]. Byte 7 decodes to dout[31:28].
- Segment decode table (segment byte → nibble; bit 7 = DP, must be 0):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
- Any other byte decodes to nibble 0 and sets its seg_err bit.
- Commit:
  - seg_raw, dout and seg_err update together, and dout_valid pulses.
  - A frame with seg_err ≠ 0 still commits; seg_err is informational only.
- Reset mid-frame: state returns to IDLE immediately and the partial frame is lost. If ss_en is still low after reset release, the remainder of that frame is ignored; capture re-arms only after ss_en has been seen high.

## Timing
- Reset values:
  - dout = 0, seg_raw = 0, seg_err = 0, dout_valid = 0, frame_err = 0.
  - Synchronizers are reset to 1 (idle line levels), so reset never produces a false edge.
  - Internal state: IDLE with the re-arm flag clear.
- Latency: dout_valid asserts SYNC_STAGES+1 clk after the raw ss_en rising edge. dout, seg_raw and seg_err are valid in the same cycle.
- The ss_clk edge and the ss_en rise are never coincident from the driver. If both arrive in the same synchronized cycle, the edge is processed first.
- dout_valid and frame_err are mutually exclusive and each lasts exactly one clk.
- Back-to-back frames need at least one idle clk (synchronized) between them. The driver guarantees about 200k.

## Structure
- Package sseg_pkg holds:
  - the 16-entry glyph constants, shared with the transmitter;
  - FRAME_BITS = 64 and NIBBLES = 8;
  - the state enum (IDLE, RECV).
- Sub-module sseg_decode: combinational 8-bit glyph → {err, nibble[3:0]}. Instantiate it eight times on the committed shift register.
- The synchronizer is a generic flop chain, inline.

## Test plan
- Driver in loopback, din = 0x12345678 → dout = 0x12345678, dout_valid one pulse, seg_err = 0, first received byte 0x7F.
- din = 0xFFFFFFFF, then 0x00000000 back-to-back → two dout_valid pulses; dout = 0xFFFFFFFF, then 0x00000000.
- Hand-driven frame with byte 3 = 0xFF (DP set) → dout[15:12] = 0, seg_err = 0x08, dout_valid pulses.
- ss_en raised after 40 bits → frame_err pulse, dout unchanged, no dout_valid.
- 65 ss_clk edges in one envelope → frame_err, dout unchanged.
- rstn asserted at bit 20, released mid-frame → all outputs 0; that frame is ignored; the next full frame decodes correctly.
